// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, fetch state and offset helpers for the fetch unit
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  typedef enum logic {
    RUN        = 1'b0,
    FAULT_HOLD = 1'b1
  } fetch_state_e;

  // Word offsets become byte displacements: sign-extend, then scale by 4.
  function automatic logic [31:0] sext16_w2b(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

  function automatic logic [31:0] sext26_w2b(input logic [25:0] off);
    return {{4{off[25]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - PC-relative branch/jump target from the decoding instruction's PC
module branch_target_calc
  import fetch_pkg::*;
(
  input  logic [31:0] if_id_pc,
  input  logic        redirect_is_jump,
  input  logic [25:0] redirect_offset,
  output logic [31:0] target
);

  logic [31:0] base;
  logic [31:0] disp;

  assign base   = if_id_pc + 32'(INSTR_BYTES);
  assign disp   = redirect_is_jump ? sext26_w2b(redirect_offset)
                                   : sext16_w2b(redirect_offset[15:0]);
  assign target = base + disp;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, IF/ID register, redirect and fetch-fault handling
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] read_instruct_addr,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic        redirect_is_jump,
  input  logic [25:0] redirect_offset,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

  logic [31:0]  pc_q;
  logic [31:0]  if_id_instr_q;
  logic [31:0]  if_id_pc_q;
  logic         if_id_valid_q;
  logic         fetch_fault_q;
  fetch_state_e state_q;

  logic [31:0]  target;
  logic         redirect_take;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a <= LAST_PC) && (a[1:0] == 2'b00);
  endfunction

  branch_target_calc u_target (
    .if_id_pc         (if_id_pc_q),
    .redirect_is_jump (redirect_is_jump),
    .redirect_offset  (redirect_offset),
    .target           (target)
  );

  // IF/ID is always invalid while faulted, so a redirect must still be honoured there to recover.
  assign redirect_take = redirect_valid && (if_id_valid_q || (state_q == FAULT_HOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= 32'h0;
      if_id_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      state_q       <= RUN;
    end else if (redirect_take) begin
      pc_q          <= target;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= pc_q;
      if_id_valid_q <= 1'b0;
      if (addr_legal(target)) state_q <= RUN;
    end else if (stall) begin
      pc_q <= pc_q;
    end else if (!addr_legal(pc_q)) begin
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= pc_q;
      if_id_valid_q <= 1'b0;
      fetch_fault_q <= 1'b1;
      state_q       <= FAULT_HOLD;
    end else begin
      if_id_instr_q <= instruction;
      if_id_pc_q    <= pc_q;
      if_id_valid_q <= 1'b1;
      pc_q          <= pc_q + 32'(INSTR_BYTES);
    end
  end

  assign read_instruct_addr = pc_q;
  assign if_id_instr        = if_id_instr_q;
  assign if_id_pc           = if_id_pc_q;
  assign if_id_valid        = if_id_valid_q;
  assign fetch_fault        = fetch_fault_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the byte-addressed, big-endian instruction memory.
- Owns the program counter and drives the memory's 32-bit read address.
- Captures the returned 32-bit word into the IF/ID pipeline register, together with its PC and a valid bit.
- Computes PC-relative branch/jump targets on redirect requests from decode, and handles stall, squash and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 256, instruction memory size in bytes; legal fetch addresses are 0 .. MEM_BYTES-4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- read_instruct_addr  output  32  byte address to instruction memory; equals pc.
- instruction  input  32  word returned combinationally by instruction memory for read_instruct_addr.
- stall  input  1  decode hazard; hold pc and IF/ID.
- redirect_valid  input  1  decode has resolved a taken branch or a jump for the instruction in IF/ID.
- redirect_is_jump  input  1  1 = jump (26-bit offset), 0 = branch (16-bit offset).
- redirect_offset  input  26  word offset; branch uses bits [15:0], jump uses all 26 bits.
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  32  registered PC of if_id_instr.
- if_id_valid  output  1  if_id_instr is a real, non-squashed instruction.
- fetch_fault  output  1  sticky; set when pc leaves the legal range.

Behaviour:
- Reset (asynchronous, immediate): pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, fetch_fault=0.
- read_instruct_addr = pc, combinationally. The memory returns data in the same cycle. Latency PC→IF/ID is one clock.
- Target computation uses base = if_id_pc + 4, since the instruction in IF/ID is the one being decoded.
  - Branch target = base + (sext16(redirect_offset[15:0]) << 2).
  - Jump target = base + (sext26(redirect_offset) << 2).
  - All arithmetic is 32-bit, modulo 2^32. Targets are always word-aligned.
- Per-cycle priority, evaluated at the rising edge:
  1. redirect_valid && if_id_valid: pc←target; if_id_valid←0 (squash the wrong-path word fetched this cycle); if_id_instr←0; if_id_pc←pc.
  2. Otherwise stall: pc, if_id_instr, if_id_pc and if_id_valid all hold.
  3. Otherwise normal fetch: if_id_instr←instruction, if_id_pc←pc, if_id_valid←1, pc←pc+4.
- A redirect overrides a simultaneous stall.
- redirect_valid while if_id_valid=0 is ignored; treated as no redirect, and stall rules apply.
- Range check: pc is out of range when pc > MEM_BYTES-4 or pc[1:0]≠0.
  - On a normal-fetch edge with pc out of range: if_id_instr←0 (NOP), if_id_valid←0, fetch_fault←1, pc holds.
  - Fetching resumes only after a redirect to a legal address. fetch_fault stays 1 until reset.
- State: RUN and FAULT_HOLD.
  - RUN → FAULT_HOLD on an out-of-range fetch.
  - FAULT_HOLD → RUN on an accepted redirect to a legal target.
  - FAULT_HOLD → RUN on reset.
- Reset asserted mid-stall or mid-redirect wins unconditionally. The first fetch after reset deassertion is RESET_PC.

Decomposition:
- Shared package fetch_pkg:
  - Constants INSTR_BYTES=4, NOP_INSTR=32'h0.
  - Fetch state enum {RUN, FAULT_HOLD}.
  - Sign-extend/shift helper functions sext16_w2b and sext26_w2b.
- One natural sub-module, branch_target_calc: combinational; inputs if_id_pc, redirect_is_jump, redirect_offset; output target.
- Sequential logic stays in the top module.

Test Plan:
- Reset then 3 free-running cycles with memory holding words A,B,C at 0,4,8 → if_id_pc 0,4,8 with if_id_instr A,B,C; if_id_valid=1 from the first edge; read_instruct_addr 0,4,8,12.
- Branch: IF/ID holds pc=28; assert redirect_valid, is_jump=0, offset=13 → next pc=84; if_id_valid=0 for one cycle; then if_id_pc=84.
- Jump backward: IF/ID pc=48, is_jump=1, offset=26'h3FFFFFA (-6) → pc=28. Repeat with pc=72/offset -12 and pc=80/offset -14 → pc=28 each time.
- Stall for 2 cycles at pc=12 → pc and IF/ID unchanged; stall together with redirect (IF/ID pc=28, offset 13) → redirect taken, pc=84.
- Fetch at pc=252 then 256 → pc=252 fetched validly; at 256: fetch_fault=1, if_id_valid=0, pc holds 256; redirect to 0 → fetch resumes, fetch_fault stays 1.
- Assert reset asynchronously mid-cycle during a redirect → outputs clear immediately; after deassertion the first read_instruct_addr is 0.
